// File: rtl/mod_updown_counter_if.sv
// -----------------------------------------------------------------------------
// mod_updown_counter_if
//   Groups the control inputs and status outputs of mod_updown_counter.
//   master : drives the controls and observes the status (testbench or parent).
//   slave  : the counter side.
//   Signals:
//     enable, up, sat_mode, load, load_value[WIDTH], clear_flag  (master -> slave)
//     count[WIDTH], tc, wrapped, at_max, at_min                  (slave -> master)
// -----------------------------------------------------------------------------
interface mod_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             up;
    logic             sat_mode;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             clear_flag;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrapped;
    logic             at_max;
    logic             at_min;

    modport master (
        output enable, up, sat_mode, load, load_value, clear_flag,
        input  count, tc, wrapped, at_max, at_min
    );

    modport slave (
        input  enable, up, sat_mode, load, load_value, clear_flag,
        output count, tc, wrapped, at_max, at_min
    );
endinterface

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//   Modulo-MODULUS up/down counter with an internal divide-by-DIV prescaler,
//   wrap or saturate behaviour at the boundaries, a terminal-count pulse and a
//   sticky wrapped flag.
//   Ports:
//     clock   : rising-edge clock for all state
//     resetn  : synchronous, active-low reset
//     bus     : mod_updown_counter_if.slave (controls in, status out)
//   Parameters:
//     WIDTH   : count width in bits
//     MODULUS : count range 0..MODULUS-1 (2..2**WIDTH)
//     DIV     : enabled cycles per count step (1..65535)
// -----------------------------------------------------------------------------
module mod_updown_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256,
    parameter int DIV     = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    mod_updown_counter_if.slave   bus
);
    localparam int               PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PRE_LAST  = PW'(DIV - 1);

    logic [PW-1:0]    prescale;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             wrapped_q;

    logic             pre_done;
    logic             at_boundary;
    logic             wraps;
    logic [WIDTH-1:0] step_count;
    logic [WIDTH-1:0] load_clamped;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pre_done     = (prescale == PRE_LAST);
        at_boundary  = bus.up ? (count_q == MAX_COUNT) : (count_q == '0);
        wraps        = at_boundary && !bus.sat_mode;
        step_count   = count_q;
        load_clamped = (bus.load_value > MAX_COUNT) ? MAX_COUNT : bus.load_value;
        if (at_boundary) begin
            // Saturating mode leaves step_count at count_q.
            if (!bus.sat_mode) step_count = bus.up ? '0 : MAX_COUNT;
        end else begin
            step_count = bus.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count_q   <= '0;
            prescale  <= '0;
            tc_q      <= 1'b0;
            wrapped_q <= 1'b0;
        end else if (bus.load) begin
            count_q  <= load_clamped;
            prescale <= '0;
            tc_q     <= 1'b0;
            if (bus.clear_flag) wrapped_q <= 1'b0;
        end else if (bus.enable) begin
            prescale <= pre_done ? '0 : prescale + PW'(1);
            if (pre_done) begin
                count_q <= step_count;
                // tc marks any step attempted at the boundary, wrapped or held.
                tc_q    <= at_boundary;
            end else begin
                tc_q <= 1'b0;
            end
            // A wrap on this edge wins over a simultaneous clear.
            if (pre_done && wraps) wrapped_q <= 1'b1;
            else if (bus.clear_flag) wrapped_q <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.clear_flag) wrapped_q <= 1'b0;
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.wrapped = wrapped_q;
    assign bus.at_max  = (count_q == MAX_COUNT);
    assign bus.at_min  = (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter
//   Two counters (WIDTH=4, MODULUS=10) with DIV=1 and DIV=3 share one set of
//   controls. A behavioural model built from plain integer arithmetic predicts
//   {count, tc, wrapped, at_max, at_min} for each after every edge.
// -----------------------------------------------------------------------------
module tb_mod_updown_counter;
    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;
    localparam int VW      = WIDTH + 4;

    logic             clock = 1'b0;
    logic             resetn;
    logic             enable, up, sat_mode, load, clear_flag;
    logic [WIDTH-1:0] load_value;

    int errors = 0;
    int checks = 0;

    mod_updown_counter_if #(.WIDTH(WIDTH)) bus_a ();
    mod_updown_counter_if #(.WIDTH(WIDTH)) bus_b ();

    assign bus_a.enable = enable;     assign bus_b.enable = enable;
    assign bus_a.up = up;             assign bus_b.up = up;
    assign bus_a.sat_mode = sat_mode; assign bus_b.sat_mode = sat_mode;
    assign bus_a.load = load;         assign bus_b.load = load;
    assign bus_a.load_value = load_value; assign bus_b.load_value = load_value;
    assign bus_a.clear_flag = clear_flag; assign bus_b.clear_flag = clear_flag;

    mod_updown_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS), .DIV(1)) dut_a (
        .clock(clock), .resetn(resetn), .bus(bus_a.slave)
    );
    mod_updown_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS), .DIV(3)) dut_b (
        .clock(clock), .resetn(resetn), .bus(bus_b.slave)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int divs  [2] = '{1, 3};
    int m_cnt [2];
    int m_pre [2];   // enabled cycles seen since the last step
    bit m_tc  [2];
    bit m_wr  [2];

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit wrapped_now = 0;
            if (!resetn) begin
                m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_wr[i] = 0;
                continue;
            end
            if (load) begin
                m_cnt[i] = (int'(load_value) >= MODULUS) ? MODULUS - 1 : int'(load_value);
                m_pre[i] = 0;
                m_tc[i]  = 0;
            end else if (enable) begin
                m_pre[i]++;
                m_tc[i] = 0;
                if (m_pre[i] == divs[i]) begin
                    bit hit = up ? (m_cnt[i] == MODULUS - 1) : (m_cnt[i] == 0);
                    m_pre[i] = 0;
                    m_tc[i]  = hit;
                    if (!hit)          m_cnt[i] = (m_cnt[i] + (up ? 1 : MODULUS - 1)) % MODULUS;
                    else if (!sat_mode) begin
                        m_cnt[i]    = up ? 0 : MODULUS - 1;
                        wrapped_now = 1;
                    end
                end
            end else begin
                m_tc[i] = 0;
            end
            if (wrapped_now)     m_wr[i] = 1;
            else if (clear_flag) m_wr[i] = 0;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec(int i);
        return {WIDTH'(m_cnt[i]), m_tc[i], m_wr[i], m_cnt[i] == MODULUS - 1, m_cnt[i] == 0};
    endfunction

    function automatic logic [VW-1:0] obs_vec(int i);
        if (i == 0) return {bus_a.count, bus_a.tc, bus_a.wrapped, bus_a.at_max, bus_a.at_min};
        return {bus_b.count, bus_b.tc, bus_b.wrapped, bus_b.at_max, bus_b.at_min};
    endfunction

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic en, input logic u, input logic s,
                          input logic ld, input logic [WIDTH-1:0] lv, input logic clr);
        enable = en; up = u; sat_mode = s; load = ld; load_value = lv; clear_flag = clr;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        set_in(1, 1, 0, 1, 4'd7, 1);   // reset must override load/enable/clear
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== 8'b0000_0001) begin
                errors++;
                $display("FAIL reset dut%0d: got %b expected %b", k, obs_vec(k), 8'b0000_0001);
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_wrap_up();
        int seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        do_reset();
        set_in(1, 1, 0, 0, '0, 0);
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (bus_a.count !== WIDTH'(seq[c]) || bus_a.tc !== (c == 9) || bus_a.wrapped !== (c >= 9)) begin
                errors++;
                $display("FAIL wrap_up cyc%0d: got count=%0d tc=%b wrapped=%b expected count=%0d tc=%b wrapped=%b",
                         c, bus_a.count, bus_a.tc, bus_a.wrapped, seq[c], c == 9, c >= 9);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL wrap_up model dut%0d cyc%0d: got %b expected %b", k, c, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_sat_down();
        int seq [4] = '{1, 0, 0, 0};
        do_reset();
        set_in(0, 0, 1, 1, 4'd2, 0);
        tick();
        load = 1'b0; enable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus_a.count !== WIDTH'(seq[c]) || bus_a.tc !== (c >= 2) || bus_a.wrapped !== 1'b0) begin
                errors++;
                $display("FAIL sat_down cyc%0d: got count=%0d tc=%b wrapped=%b expected count=%0d tc=%b wrapped=0",
                         c, bus_a.count, bus_a.tc, bus_a.wrapped, seq[c], c >= 2);
            end
        end
    endtask

    task automatic test_prescale();
        logic en_pat [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        int   seq    [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
        do_reset();
        set_in(0, 1, 0, 0, '0, 0);
        for (int c = 0; c < 11; c++) begin
            enable = en_pat[c];
            tick();
            checks++;
            if (bus_b.count !== WIDTH'(seq[c]) || bus_b.tc !== 1'b0) begin
                errors++;
                $display("FAIL prescale edge%0d: got count=%0d tc=%b expected count=%0d tc=0",
                         c + 1, bus_b.count, bus_b.tc, seq[c]);
            end
        end
    endtask

    task automatic test_load_clamp();
        do_reset();
        set_in(1, 1, 0, 0, '0, 0);
        tick();                         // dut_b prescaler now part-way
        set_in(1, 1, 0, 1, 4'd13, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== {4'd9, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL load_clamp dut%0d: got %b expected %b", k, obs_vec(k), {4'd9, 4'b0010});
            end
        end
        // Prescaler restarted: dut_b must need three more enabled edges.
        load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus_b.count !== ((c == 2) ? 4'd0 : 4'd9)) begin
                errors++;
                $display("FAIL load_prescale cyc%0d: got %0d expected %0d", c, bus_b.count, (c == 2) ? 0 : 9);
            end
        end
    endtask

    task automatic test_wrap_clear();
        do_reset();
        set_in(0, 1, 0, 1, 4'd9, 0);
        tick();
        set_in(1, 1, 0, 0, '0, 1);      // wrap and clear together on dut_a
        tick();
        checks++;
        if (bus_a.wrapped !== 1'b1 || bus_a.count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_vs_clear: got wrapped=%b count=%0d expected wrapped=1 count=0", bus_a.wrapped, bus_a.count);
        end
        set_in(0, 1, 0, 0, '0, 1);
        tick();
        checks++;
        if (bus_a.wrapped !== 1'b0) begin
            errors++;
            $display("FAIL clear_alone: got wrapped=%b expected 0", bus_a.wrapped);
        end
        clear_flag = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(0, 1, 0, 1, 4'd7, 0);
        tick();
        set_in(1, 1, 0, 0, '0, 0);
        tick(); tick();                 // dut_b: count 7, prescaler 2
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checks++;
        if (obs_vec(1) !== 8'b0000_0001) begin
            errors++;
            $display("FAIL reset_mid: got %b expected %b", obs_vec(1), 8'b0000_0001);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus_b.count !== ((c == 2) ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL reset_resume cyc%0d: got %0d expected %0d", c, bus_b.count, (c == 2) ? 1 : 0);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            resetn     = ($urandom_range(0, 99) >= 2);
            enable     = ($urandom_range(0, 3) != 0);
            up         = ($urandom_range(0, 7) != 0) ? up : ~up;
            sat_mode   = ($urandom_range(0, 15) != 0) ? sat_mode : ~sat_mode;
            load       = ($urandom_range(0, 19) == 0);
            load_value = WIDTH'($urandom_range(0, 15));
            clear_flag = ($urandom_range(0, 9) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: got %b expected %b", k, c, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        set_in(0, 1, 0, 0, '0, 0);
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_prescale();
        test_load_clamp();
        test_wrap_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
